// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory slave between two masters,
// one transfer per grant, with a sticky watchdog for a slave stuck in waitrequest.
module mips_bus_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WATCHDOG_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant,
  output logic                timeout
);

  localparam int CNT_W = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WATCHDOG_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout;

  logic             w_req0;
  logic             w_req1;
  logic             w_owner_req;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_req0      = m0_read | m0_write;
  assign w_req1      = m1_read | m1_write;
  assign w_owner_req = (r_state == OWN0) ? w_req0 : w_req1;

  // Saturating stall count; only meaningful while an owner is stalled.
  always_comb begin
    w_cnt_next = r_stall_cnt;
    if ((WATCHDOG_CYCLES > 0) && (r_stall_cnt != CNT_MAX))
      w_cnt_next = r_stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_stall_cnt <= '0;
          if (w_req0 && (!w_req1 || r_last)) begin
            r_state <= OWN0;
            r_last  <= 1'b0;
          end else if (w_req1) begin
            r_state <= OWN1;
            r_last  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          // Completion or an owner abandoning its request both end the grant.
          if (!w_owner_req || !s_waitrequest) begin
            r_state     <= IDLE;
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= w_cnt_next;
            if ((WATCHDOG_CYCLES > 0) && (w_cnt_next == CNT_MAX))
              r_timeout <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    case (r_state)
      OWN0: begin
        s_address    = m0_address;
        s_read       = m0_read;
        s_write      = m0_write;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
      end
      OWN1: begin
        s_address    = m1_address;
        s_read       = m1_read;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest = (r_state == OWN0) ? s_waitrequest : 1'b1;
  assign m1_waitrequest = (r_state == OWN1) ? s_waitrequest : 1'b1;
  assign m0_readdata    = s_readdata;
  assign m1_readdata    = s_readdata;
  assign grant          = {r_state == OWN1, r_state == OWN0};
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: two instances share stimulus, one with a
// 2-cycle watchdog and one with a 5-cycle watchdog.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;

  logic        m0_waitrequest, m1_waitrequest, s_read, s_write, timeout;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  logic        d5_m0_waitrequest, d5_m1_waitrequest, d5_s_read, d5_s_write, d5_timeout;
  logic [31:0] d5_m0_readdata, d5_m1_readdata, d5_s_address, d5_s_writedata;
  logic [3:0]  d5_s_byteenable;
  logic [1:0]  d5_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WATCHDOG_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout(timeout)
  );

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WATCHDOG_CYCLES(5)) dut5 (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(d5_m0_waitrequest), .m0_readdata(d5_m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(d5_m1_waitrequest), .m1_readdata(d5_m1_readdata),
    .s_address(d5_s_address), .s_read(d5_s_read), .s_write(d5_s_write),
    .s_writedata(d5_s_writedata), .s_byteenable(d5_s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(d5_grant), .timeout(d5_timeout)
  );

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_address = '0; m1_address = '0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0;
    step(); step();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL reset_wait got %b exp 11", {m0_waitrequest, m1_waitrequest}); end
    checks++; if ({s_read, s_write, s_address} !== 34'd0) begin errors++; $display("FAIL reset_slave got %h exp 0", {s_read, s_write, s_address}); end
    step();
    reset = 1'b0;
    $display("test_reset: reset state sampled");
  endtask

  task automatic test_single_read();
    m0_read = 1'b1; m0_address = 32'h0000_0010;
    s_waitrequest = 1'b0; s_readdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (grant !== 2'b00 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL read_arb_cycle got grant %b wait %b exp 00/1", grant, m0_waitrequest); end
    step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_grant got %b exp 01", grant); end
    checks++; if (s_read !== 1'b1 || s_address !== 32'h10) begin errors++; $display("FAIL read_slave got rd %b addr %h exp 1/00000010", s_read, s_address); end
    checks++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data got wait %b data %h exp 0/deadbeef", m0_waitrequest, m0_readdata); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL read_m1_wait got %b exp 1", m1_waitrequest); end
    step();
    m0_read = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || s_read !== 1'b0) begin errors++; $display("FAIL read_after got grant %b rd %b exp 00/0", grant, s_read); end
    $display("test_single_read: m0 read 0x10 -> deadbeef");
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    m0_write = 1'b1; m0_address = 32'h100; m0_writedata = 32'h1111_1111; m0_byteenable = 4'hF;
    m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'h2222_2222; m1_byteenable = 4'h3;
    s_waitrequest = 1'b0;
    step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL b2b_first_grant got %b exp 01", grant); end
    checks++; if (s_write !== 1'b1 || s_address !== 32'h100 || s_writedata !== 32'h1111_1111 || s_byteenable !== 4'hF)
      begin errors++; $display("FAIL b2b_m0_fwd got wr %b addr %h data %h be %h exp 1/100/11111111/f", s_write, s_address, s_writedata, s_byteenable); end
    checks++; if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_wait0 got m0 %b m1 %b exp 0/1", m0_waitrequest, m1_waitrequest); end
    step();
    m0_write = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_bubble got grant %b wr %b m1wait %b exp 00/0/1", grant, s_write, m1_waitrequest); end
    step(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL b2b_second_grant got %b exp 10", grant); end
    checks++; if (s_write !== 1'b1 || s_address !== 32'h200 || s_writedata !== 32'h2222_2222 || s_byteenable !== 4'h3)
      begin errors++; $display("FAIL b2b_m1_fwd got wr %b addr %h data %h be %h exp 1/200/22222222/3", s_write, s_address, s_writedata, s_byteenable); end
    checks++; if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_wait1 got m0 %b m1 %b exp 1/0", m0_waitrequest, m1_waitrequest); end
    step();
    m1_write = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_end got %b exp 00", grant); end
    $display("test_back_to_back: m0 write then m1 write");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [12];
    exp_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    m0_read = 1'b1; m0_address = 32'h40;
    m1_read = 1'b1; m1_address = 32'h80;
    s_waitrequest = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (grant !== exp_seq[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, grant, exp_seq[i]); end
      checks++; if ({m1_waitrequest, m0_waitrequest} !== ~exp_seq[i]) begin errors++; $display("FAIL rr_wait[%0d] got %b exp %b", i, {m1_waitrequest, m0_waitrequest}, ~exp_seq[i]); end
      step();
    end
    m0_read = 1'b0; m1_read = 1'b0;
    step();
    $display("test_round_robin: 12 cycles of alternating reads");
  endtask

  task automatic test_watchdog();
    logic [3:0] exp_to2;
    exp_to2 = 4'b1100;
    m1_write = 1'b1; m1_address = 32'h300; m1_writedata = 32'hCAFE_0001; m1_byteenable = 4'hF;
    s_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) s_waitrequest = 1'b0;
      #1;
      checks++; if (grant !== 2'b10 || d5_grant !== 2'b10) begin errors++; $display("FAIL wd_grant[%0d] got %b/%b exp 10", i, grant, d5_grant); end
      checks++; if (d5_m1_waitrequest !== s_waitrequest) begin errors++; $display("FAIL wd_mirror[%0d] got %b exp %b", i, d5_m1_waitrequest, s_waitrequest); end
      checks++; if (timeout !== exp_to2[i]) begin errors++; $display("FAIL wd2_timeout[%0d] got %b exp %b", i, timeout, exp_to2[i]); end
      checks++; if (d5_timeout !== 1'b0) begin errors++; $display("FAIL wd5_timeout[%0d] got %b exp 0", i, d5_timeout); end
    end
    step();
    m1_write = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || d5_grant !== 2'b00) begin errors++; $display("FAIL wd_done got %b/%b exp 00", grant, d5_grant); end
    checks++; if (timeout !== 1'b1 || d5_timeout !== 1'b0) begin errors++; $display("FAIL wd_sticky got %b/%b exp 1/0", timeout, d5_timeout); end
    step(); #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_hold got %b exp 1", timeout); end
    $display("test_watchdog: m1 write stalled 3 cycles");
  endtask

  task automatic test_reset_mid_transfer();
    m0_read = 1'b1; m0_address = 32'h500;
    s_waitrequest = 1'b1;
    step(); #1;
    checks++; if (grant !== 2'b01 || s_read !== 1'b1) begin errors++; $display("FAIL rst_own got grant %b rd %b exp 01/1", grant, s_read); end
    reset = 1'b1;
    step();
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 32'h600;
    #1;
    checks++; if (grant !== 2'b00 || s_read !== 1'b0) begin errors++; $display("FAIL rst_edge got grant %b rd %b exp 00/0", grant, s_read); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout_clear got %b exp 0", timeout); end
    step(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_hold got %b exp 00", grant); end
    reset = 1'b0;
    s_waitrequest = 1'b0;
    step(); #1;
    checks++; if (grant !== 2'b10 || s_read !== 1'b1 || s_address !== 32'h600) begin errors++; $display("FAIL rst_m1_first got grant %b rd %b addr %h exp 10/1/600", grant, s_read, s_address); end
    step();
    m1_read = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_end got %b exp 00", grant); end
    $display("test_reset_mid_transfer: reset during stalled m0 read");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_round_robin();
    test_watchdog();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master arbiter sharing one Avalon-style memory slave (simple_memory-compatible port set) between the mips_cpu_bus instance (master 0) and a second requester such as a loader or DMA engine (master 1).
- Round-robin ownership, one transfer per grant; the owner's signals are forwarded to the slave and the slave's waitrequest is routed back to the owner.
- Includes a stall watchdog that flags a slave stuck in waitrequest.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- WATCHDOG_CYCLES, 0, consecutive stalled cycles in one transfer before timeout is raised; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_address, m1_address  in  ADDR_W  master address.
- m0_read, m1_read  in  1  read request.
- m0_write, m1_write  in  1  write request.
- m0_writedata, m1_writedata  in  DATA_W  write data.
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes.
- m0_waitrequest, m1_waitrequest  out  1  stall to master.
- m0_readdata, m1_readdata  out  DATA_W  read data, both equal to s_readdata.
- s_address  out  ADDR_W  to slave.
- s_read, s_write  out  1  to slave.
- s_writedata  out  DATA_W  to slave.
- s_byteenable  out  DATA_W/8  to slave.
- s_waitrequest  in  1  from slave.
- s_readdata  in  DATA_W  from slave.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Request definitions: reqN = mN_read | mN_write.
- Transfer completes in a cycle where the owner has reqN=1 and s_waitrequest=0.
- States: IDLE, OWN0, OWN1.
- Registers: state, last (last master granted), stall_cnt, timeout.
- Reset values: state=IDLE, last=1 (so master 0 wins the first tie), stall_cnt=0, timeout=0.
- IDLE:
  - No request: stay in IDLE.
  - Only reqN: go to OWNN.
  - Both requests: go to OWN of the master != last.
  - Entering OWNN sets last=N.
- OWNN:
  - Transfer completes: go to IDLE.
  - Owner drops reqN before completion (protocol violation): go to IDLE with no transfer counted.
  - Otherwise stay in OWNN.
- Each transfer therefore costs one arbitration cycle plus its slave cycles, followed by a mandatory IDLE bubble.
- Latency: request first visible in cycle N, slave sees it in N+1; with zero slave wait it completes in N+1 and the state is IDLE at N+2.
- Datapath (combinational from state):
  - In OWNN, s_address, s_read, s_write, s_writedata and s_byteenable equal master N's inputs.
  - In IDLE, all s_* outputs are 0.
  - Simultaneous read and write from the owner are forwarded unchanged; benches must not drive this case.
- mN_waitrequest = s_waitrequest when state==OWNN, else 1; a master that is not the owner is always stalled.
- mN_readdata = s_readdata unconditionally; it is valid only in the owner's completion cycle.
- grant: 01 in OWN0, 10 in OWN1, 00 in IDLE.
- Watchdog:
  - stall_cnt increments each OWN cycle with s_waitrequest=1 and saturates at WATCHDOG_CYCLES.
  - stall_cnt clears in IDLE and on completion.
  - timeout sets when stall_cnt reaches WATCHDOG_CYCLES (WATCHDOG_CYCLES>0) and stays set until reset.
  - The transfer is not aborted.
- Reset mid-transfer: state is IDLE from the edge at which reset is sampled, s_read=s_write=0 from that edge, and any in-flight transfer is dropped.
- Requests asserted during reset are arbitrated normally from the first cycle after reset falls.

Test Plan:
- m0 read at 0x00000010, slave waitrequest=0, readdata 0xDEADBEEF -> grant=01 one cycle after request; s_read=1 and s_address=0x10 in that cycle; m0 sees waitrequest=0 with readdata 0xDEADBEEF; grant=00 next cycle.
- m0 and m1 both write from reset -> m0 served first, then IDLE bubble, then m1; slave sees m0 writedata/byteenable followed by m1's; m1_waitrequest=1 throughout m0's ownership.
- Both masters hold continuous reads for 6 transfers -> grant sequence 01,00,10,00,01,00,10,... with strict alternation and no starvation.
- m1 write with slave waitrequest high for 3 cycles, WATCHDOG_CYCLES=5 -> m1_waitrequest mirrors the slave; completion on the 4th owned cycle; timeout stays 0.
- Same transfer with WATCHDOG_CYCLES=2 -> timeout rises after 2 stalled cycles, stays 1 after completion, clears only on reset.
- reset asserted while in OWN0 with the slave stalling -> grant=00 and s_read=0 from the reset edge; after reset a pending m1 request is granted first if m0 is idle.
